// File: rtl/wb_init_pkg.sv
// rtl/wb_init_pkg.sv - shared types and constants for the Caravel Wishbone initiator
package wb_init_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          WB_DATA_W       = 32;
  localparam int          WB_SEL_W        = 4;
  localparam logic [31:0] CARAVEL_WB_BASE = 32'h3000_0000;

  // Word offset to byte address; the add wraps modulo 2^32 by construction.
  function automatic logic [31:0] wb_byte_addr(input logic [31:0] base, input logic [31:0] word_off);
    return base + {word_off[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/wb_caravel_initiator_if.sv
// rtl/wb_caravel_initiator_if.sv - command/response and Wishbone master signal bundle
interface wb_caravel_initiator_if #(
  parameter int ADR_W = 8
);
  import wb_init_pkg::*;

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_we_i;
  logic [ADR_W-1:0]     cmd_adr_i;
  logic [WB_DATA_W-1:0] cmd_dat_i;
  logic [WB_SEL_W-1:0]  cmd_sel_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [WB_DATA_W-1:0] rsp_rdata_o;
  logic                 rsp_err_o;
  logic                 busy_o;

  logic                 wbm_cyc_o;
  logic                 wbm_stb_o;
  logic                 wbm_we_o;
  logic [WB_SEL_W-1:0]  wbm_sel_o;
  logic [31:0]          wbm_adr_o;
  logic [WB_DATA_W-1:0] wbm_dat_o;
  logic                 wbm_ack_i;
  logic [WB_DATA_W-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  rsp_ready_i, wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output rsp_ready_i, wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - 8-bit ack-wait counter flagging when the strobe has waited too long
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_caravel_initiator.sv
// rtl/wb_caravel_initiator.sv - single-command Wishbone classic initiator with ack timeout
module wb_caravel_initiator
  import wb_init_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = CARAVEL_WB_BASE,
  parameter int          ADR_W          = 8,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input logic                    wb_clk_i,
  input logic                    wb_rst_n_i,
  wb_caravel_initiator_if.master bus
);

  state_t               state;
  logic                 ready_q;
  logic                 busy_q;
  logic                 cyc_q;
  logic                 stb_q;
  logic                 we_q;
  logic [WB_SEL_W-1:0]  sel_q;
  logic [31:0]          adr_q;
  logic [WB_DATA_W-1:0] dat_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic [WB_DATA_W-1:0] rsp_rdata_q;

  logic [ADR_W-1:0]     adr_in;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 expired;

  assign adr_in  = bus.cmd_adr_i;
  assign cnt_en  = (state == BUS) && !bus.wbm_ack_i;
  assign cnt_clr = (state == RESP) && bus.rsp_ready_i;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  // ready_q mirrors state==IDLE but is a flop so it can sit at 0 during reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i && ready_q) begin
            we_q    <= bus.cmd_we_i;
            sel_q   <= bus.cmd_sel_i;
            dat_q   <= bus.cmd_dat_i;
            adr_q   <= wb_byte_addr(BASE_ADDRESS, 32'(adr_in));
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= BUS;
          end else begin
            ready_q <= 1'b1;
          end
        end
        BUS: begin
          // Ack is checked first so it wins over a simultaneous expiry.
          if (bus.wbm_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : bus.wbm_dat_i;
            state       <= RESP;
          end else if (expired) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = stb_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_caravel_initiator.sv
// tb/tb_wb_caravel_initiator.sv - randomized self-checking bench for wb_caravel_initiator
module tb_wb_caravel_initiator;
  import wb_init_pkg::*;

  localparam logic [31:0] BASE0 = 32'h3000_0000;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFF0;
  localparam int          TO    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_caravel_initiator_if #(.ADR_W(8)) if0 ();
  wb_caravel_initiator_if #(.ADR_W(8)) if1 ();

  // The second instance sees identical stimulus; only its base address differs.
  assign if1.cmd_valid_i = if0.cmd_valid_i;
  assign if1.cmd_we_i    = if0.cmd_we_i;
  assign if1.cmd_adr_i   = if0.cmd_adr_i;
  assign if1.cmd_dat_i   = if0.cmd_dat_i;
  assign if1.cmd_sel_i   = if0.cmd_sel_i;
  assign if1.rsp_ready_i = if0.rsp_ready_i;
  assign if1.wbm_ack_i   = if0.wbm_ack_i;
  assign if1.wbm_dat_i   = if0.wbm_dat_i;

  wb_caravel_initiator #(
    .BASE_ADDRESS(BASE0), .ADR_W(8), .TIMEOUT_CYCLES(TO)
  ) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(if0)
  );

  wb_caravel_initiator #(
    .BASE_ADDRESS(BASE1), .ADR_W(8), .TIMEOUT_CYCLES(TO)
  ) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(if1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut0"}, 32'(|{if0.cmd_ready_o, if0.rsp_valid_o, if0.rsp_rdata_o, if0.rsp_err_o,
                               if0.busy_o, if0.wbm_cyc_o, if0.wbm_stb_o, if0.wbm_we_o,
                               if0.wbm_sel_o, if0.wbm_adr_o, if0.wbm_dat_o}), 32'd0);
    check({tag, "_dut1"}, 32'(|{if1.cmd_ready_o, if1.rsp_valid_o, if1.rsp_rdata_o, if1.rsp_err_o,
                               if1.busy_o, if1.wbm_cyc_o, if1.wbm_stb_o, if1.wbm_we_o,
                               if1.wbm_sel_o, if1.wbm_adr_o, if1.wbm_dat_o}), 32'd0);
  endtask

  task automatic wait_ready(output bit ok);
    int guard = 0;
    while (if0.cmd_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = (if0.cmd_ready_o === 1'b1);
    if (!ok) check("cmd_ready_wait", 32'(if0.cmd_ready_o), 32'd1);
  endtask

  // d: stb cycle (1-based) on which the responder acks, 0 = never acks.
  task automatic run_txn(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int d, input logic [31:0] rd, input int rwait);
    int          cycles;
    int          exp_cycles;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
    bit          ok;
    exp_a0 = BASE0 + 32'(adr) * 32'd4;
    exp_a1 = BASE1 + 32'(adr) * 32'd4;
    if (d != 0 && d <= TO) begin
      exp_cycles = d;
      exp_err    = 1'b0;
      exp_rdata  = we ? 32'd0 : rd;
    end else begin
      exp_cycles = TO;
      exp_err    = 1'b1;
      exp_rdata  = 32'd0;
    end
    if0.cmd_valid_i = 1'b1;
    if0.cmd_we_i    = we;
    if0.cmd_adr_i   = adr;
    if0.cmd_dat_i   = dat;
    if0.cmd_sel_i   = sel;
    if0.wbm_ack_i   = 1'b0;
    wait_ready(ok);
    if (!ok) begin
      if0.cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if0.cmd_valid_i = 1'b0;
    if0.cmd_we_i    = 1'($urandom);
    if0.cmd_adr_i   = 8'($urandom);
    if0.cmd_dat_i   = $urandom;
    if0.cmd_sel_i   = 4'($urandom);
    check("cmd_ready_busy", 32'(if0.cmd_ready_o), 32'd0);
    cycles = 0;
    while (if0.wbm_cyc_o === 1'b1 && cycles < 40) begin
      cycles++;
      check("stb", 32'(if0.wbm_stb_o), 32'd1);
      check("adr", if0.wbm_adr_o, exp_a0);
      check("adr_wrap", if1.wbm_adr_o, exp_a1);
      check("wdat", if0.wbm_dat_o, dat);
      check("we", 32'(if0.wbm_we_o), 32'(we));
      check("sel", 32'(if0.wbm_sel_o), 32'(sel));
      check("busy", 32'(if0.busy_o), 32'd1);
      check("rsp_valid_in_bus", 32'(if0.rsp_valid_o), 32'd0);
      if0.wbm_ack_i = (cycles == d);
      if0.wbm_dat_i = (cycles == d) ? rd : $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    if0.wbm_ack_i = 1'b0;
    check("cyc_cycles", 32'(cycles), 32'(exp_cycles));
    check("stb_low", 32'(if0.wbm_stb_o), 32'd0);
    check("rsp_valid", 32'(if0.rsp_valid_o), 32'd1);
    check("rsp_err", 32'(if0.rsp_err_o), 32'(exp_err));
    check("rsp_rdata", if0.rsp_rdata_o, exp_rdata);
    check("rsp_rdata_dut1", if1.rsp_rdata_o, exp_rdata);
    check("rsp_err_dut1", 32'(if1.rsp_err_o), 32'(exp_err));
    for (int k = 0; k < rwait; k++) begin
      if0.rsp_ready_i = 1'b0;
      if0.wbm_ack_i   = 1'($urandom);
      if0.wbm_dat_i   = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(if0.rsp_valid_o), 32'd1);
      check("hold_rdata", if0.rsp_rdata_o, exp_rdata);
      check("hold_err", 32'(if0.rsp_err_o), 32'(exp_err));
      check("hold_cmd_ready", 32'(if0.cmd_ready_o), 32'd0);
      check("hold_cyc", 32'(if0.wbm_cyc_o), 32'd0);
    end
    if0.wbm_ack_i   = 1'b0;
    if0.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.rsp_ready_i = 1'b0;
    check("post_rsp_valid", 32'(if0.rsp_valid_o), 32'd0);
    check("post_cmd_ready", 32'(if0.cmd_ready_o), 32'd1);
    check("post_busy", 32'(if0.busy_o), 32'd0);
  endtask

  task automatic reset_mid_cycle();
    bit ok;
    if0.cmd_valid_i = 1'b1;
    if0.cmd_we_i    = 1'b0;
    if0.cmd_adr_i   = 8'($urandom);
    if0.wbm_ack_i   = 1'b0;
    wait_ready(ok);
    if (!ok) return;
    @(posedge clk);
    @(negedge clk);
    if0.cmd_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_cyc", 32'(if0.wbm_cyc_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    #1 check_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(if0.cmd_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("ready_after_release", 32'(if0.cmd_ready_o), 32'd1);
    check("busy_after_release", 32'(if0.busy_o), 32'd0);
    check("valid_after_release", 32'(if0.rsp_valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.cmd_valid_i = 1'b0;
    if0.cmd_we_i    = 1'b0;
    if0.cmd_adr_i   = '0;
    if0.cmd_dat_i   = '0;
    if0.cmd_sel_i   = '0;
    if0.rsp_ready_i = 1'b0;
    if0.wbm_ack_i   = 1'b0;
    if0.wbm_dat_i   = '0;
    #12 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_first", 32'(if0.cmd_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("ready_idle", 32'(if0.cmd_ready_o), 32'd1);

    run_txn(1'b1, 8'h01, 32'hDEAD_BEEF, 4'hF, 1, 32'h1234_5678, 0);
    run_txn(1'b0, 8'h02, 32'h0, 4'hF, 3, 32'h0000_0051, 0);
    run_txn(1'b0, 8'h03, 32'h0, 4'h3, 0, 32'hAAAA_5555, 1);
    run_txn(1'b0, 8'h04, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 5);
    reset_mid_cycle();
    run_txn(1'b0, 8'h05, 32'h0, 4'hF, TO, 32'h0BAD_F00D, 0);
    run_txn(1'b0, 8'h05, 32'h0, 4'hF, TO + 1, 32'h0BAD_F00D, 0);
    run_txn(1'b1, 8'hFF, 32'h0102_0304, 4'h1, TO - 1, 32'hFFFF_FFFF, 2);

    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom), 8'($urandom), $urandom, 4'($urandom),
              int'($urandom_range(0, 20)), $urandom, int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
